spi_cmd_sequencer: RTL and testbench

//  Command-level controller behind the SPI byte receiver. Parses each SPI frame
//  (one ssel_ low period) into opcode + address + payload.

---
 rtl/spi_cmd_sequencer.sv | 269 ++++++++++++++++++++++++++
 tb/tb_spi_cmd_sequencer.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_sequencer.sv
// spi_cmd_sequencer
// Command-level controller that sits behind the SPI byte receiver. Each frame
// (one chip-select low period) carries an opcode byte, a two-byte big-endian
// address and then either write data or dummy bytes that clock out read data.
// Transactions go to a register/memory port: writes use a valid/ready
// handshake and reads use a request pulse followed by an acknowledge pulse.
// Status and read data are returned to the MISO shifter through tx_data/tx_load.

module spi_cmd_sequencer #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              frame_end,
  output logic [7:0]        tx_data,
  output logic              tx_load,
  output logic              wr_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  input  logic              wr_ready,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  input  logic              rd_ack,
  output logic              busy,
  output logic              err
);

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_WRITE = 8'h01;
  localparam logic [7:0] OP_READ  = 8'h02;

  // S_IDLE waits for the opcode byte. The ADDR states wait for the address
  // bytes. The DATA states handle the payload. S_SKIP (NOP) and S_ERROR
  // swallow the remaining bytes of the frame.
  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR_HI,
    S_ADDR_LO,
    S_WR_DATA,
    S_RD_DATA,
    S_SKIP,
    S_ERROR
  } state_t;

  // Sequencer state
  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_is_read;
  logic              w_is_read_nxt;

  // Address tracking
  logic [7:0]        r_addr_hi;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       w_addr_full;
  logic [ADDR_W-1:0] w_addr_new;
  logic [ADDR_W-1:0] w_addr_eff;
  logic              w_addr_inc;

  // Transaction port registers
  logic              r_wr_valid;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [7:0]        r_wr_data;
  logic              r_rd_req;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_rd_pend;

  // MISO feedback
  logic [7:0]        r_tx_data;
  logic              r_tx_load;

  // Status flags
  logic              r_badop;
  logic              r_overrun;

  // Decoded strobes
  logic              w_wr_stuck;
  logic              w_overrun;
  logic              w_rx_ok;
  logic              w_opcode_rx;
  logic              w_badop_set;
  logic              w_addr_hi_ld;
  logic              w_addr_lo_ld;
  logic              w_wr_issue;
  logic              w_rd_issue;

  // A byte overruns the port when the previous write is still waiting for
  // wr_ready or the previous read has not been acknowledged. The ack cycle
  // itself still counts as outstanding: that read data would be too late for
  // the byte that has just started shifting.
  assign w_wr_stuck = r_wr_valid && !wr_ready;
  assign w_overrun  = rx_valid && (w_wr_stuck || r_rd_pend);
  assign w_rx_ok    = rx_valid && !w_overrun;

  // The address advances once per completed transaction. A transaction issued
  // in the same cycle as the previous one completes must already use the
  // advanced address.
  assign w_addr_inc  = (r_wr_valid && wr_ready) || (r_rd_pend && rd_ack);
  assign w_addr_eff  = r_addr + {{(ADDR_W-1){1'b0}}, w_addr_inc};
  assign w_addr_full = {r_addr_hi, rx_data};
  assign w_addr_new  = w_addr_full[ADDR_W-1:0];

  // State register
  // NOTE: sequential blocks use non-blocking assignments so that every
  // register samples the pre-edge values, whatever order the blocks run in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_is_read <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_is_read <= w_is_read_nxt;
    end
  end

  // Next-state decode and per-byte action strobes
  // NOTE: every signal gets a default first, so no path through the case
  // statement can leave a value unassigned and infer a latch.
  always_comb begin
    w_state_nxt   = r_state;
    w_is_read_nxt = r_is_read;
    w_opcode_rx   = 1'b0;
    w_badop_set   = 1'b0;
    w_addr_hi_ld  = 1'b0;
    w_addr_lo_ld  = 1'b0;
    w_wr_issue    = 1'b0;
    w_rd_issue    = 1'b0;

    if (w_rx_ok) begin
      unique case (r_state)
        S_IDLE: begin
          w_opcode_rx = 1'b1;
          unique case (rx_data)
            OP_NOP:   w_state_nxt = S_SKIP;
            OP_WRITE: begin
              w_state_nxt   = S_ADDR_HI;
              w_is_read_nxt = 1'b0;
            end
            OP_READ: begin
              w_state_nxt   = S_ADDR_HI;
              w_is_read_nxt = 1'b1;
            end
            default: begin
              w_state_nxt = S_ERROR;
              w_badop_set = 1'b1;
            end
          endcase
        end
        S_ADDR_HI: begin
          w_addr_hi_ld = 1'b1;
          w_state_nxt  = S_ADDR_LO;
        end
        S_ADDR_LO: begin
          w_addr_lo_ld = 1'b1;
          if (r_is_read) begin
            // Prefetch the first location so its data is ready for the next byte.
            w_rd_issue  = 1'b1;
            w_state_nxt = S_RD_DATA;
          end else begin
            w_state_nxt = S_WR_DATA;
          end
        end
        S_WR_DATA: w_wr_issue = 1'b1;
        S_RD_DATA: w_rd_issue = 1'b1;
        default:   ;  // S_SKIP / S_ERROR ignore bytes until frame_end
      endcase
    end

    if (w_overrun) begin
      w_state_nxt = S_ERROR;
    end

    // The byte in the same cycle has already been acted on above; the frame
    // closing always wins the state.
    if (frame_end) begin
      w_state_nxt = S_IDLE;
    end
  end

  // Address capture and post-transaction increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr_hi <= 8'h00;
      r_addr    <= '0;
    end else begin
      if (w_addr_hi_ld) begin
        r_addr_hi <= rx_data;
      end
      if (w_addr_lo_ld) begin
        r_addr <= w_addr_new;
      end else begin
        r_addr <= w_addr_eff;
      end
    end
  end

  // Write port: a request stays up, unchanged, until wr_ready accepts it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_valid <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= 8'h00;
    end else if (w_wr_issue) begin
      r_wr_valid <= 1'b1;
      r_wr_addr  <= w_addr_eff;
      r_wr_data  <= rx_data;
    end else if (wr_ready) begin
      r_wr_valid <= 1'b0;
    end
  end

  // Read port: one-cycle request pulse, pending until rd_ack
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_req  <= 1'b0;
      r_rd_addr <= '0;
      r_rd_pend <= 1'b0;
    end else begin
      r_rd_req <= w_rd_issue;
      if (w_rd_issue) begin
        r_rd_addr <= w_addr_lo_ld ? w_addr_new : w_addr_eff;
        r_rd_pend <= 1'b1;
      end else if (rd_ack) begin
        r_rd_pend <= 1'b0;
      end
    end
  end

  // MISO feedback: the opcode byte returns status, and each read ack returns data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_data <= 8'h00;
      r_tx_load <= 1'b0;
    end else begin
      r_tx_load <= 1'b0;
      if (w_opcode_rx) begin
        r_tx_data <= {6'b0, r_overrun, r_badop};
        r_tx_load <= 1'b1;
      end else if (r_rd_pend && rd_ack) begin
        r_tx_data <= rd_data;
        r_tx_load <= 1'b1;
      end
    end
  end

  // Flags: reported and cleared by each opcode byte; a new event in the same cycle wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_badop   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_badop   <= w_badop_set | (r_badop & ~w_opcode_rx);
      r_overrun <= w_overrun | (r_overrun & ~w_opcode_rx);
    end
  end

  assign tx_data  = r_tx_data;
  assign tx_load  = r_tx_load;
  assign wr_valid = r_wr_valid;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;
  assign rd_req   = r_rd_req;
  assign rd_addr  = r_rd_addr;
  assign busy     = (r_state != S_IDLE) || r_wr_valid || r_rd_pend;
  assign err      = r_overrun | r_badop;

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Bench for spi_cmd_sequencer. A frame-level reference model turns each frame
// into its expected writes, reads and MISO bytes. A monitor pops those
// expectations whenever the DUT presents a handshake or a tx_load.

module tb_spi_cmd_sequencer;

  localparam int GAP = 8;  // idle cycles between SPI bytes

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        frame_end;
  logic [7:0]  tx_data;
  logic        tx_load;
  logic        wr_valid;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_ready;
  logic        rd_req;
  logic [15:0] rd_addr;
  logic [7:0]  rd_data;
  logic        rd_ack;
  logic        busy;
  logic        err;

  spi_cmd_sequencer #(.ADDR_W(16)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .frame_end(frame_end), .tx_data(tx_data), .tx_load(tx_load),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_ack(rd_ack), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Expected traffic
  logic [23:0] exp_wr[$];  // {addr, data}
  logic [15:0] exp_rd[$];
  logic [7:0]  exp_tx[$];

  // Reference model state and memory images (model copy, slave copy)
  bit          m_overrun = 1'b0;
  bit          m_badop   = 1'b0;
  logic [7:0]  m_mem[int];
  logic [7:0]  s_mem[int];

  // Responder controls
  bit          wr_stall = 1'b0;
  int          wr_wait  = 0;
  int          wr_lat   = 0;
  bit          rd_busy  = 1'b0;
  int          rd_cnt   = 0;
  logic [15:0] rd_a     = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] mem_default(input logic [15:0] a);
    logic [15:0] t;
    t = a * 16'd37 + {8'h00, a[15:8]} + 16'd11;
    return t[7:0];
  endfunction

  function automatic logic [7:0] m_rd(input logic [15:0] a);
    return m_mem.exists(int'(a)) ? m_mem[int'(a)] : mem_default(a);
  endfunction

  function automatic logic [7:0] s_rd(input logic [15:0] a);
    return s_mem.exists(int'(a)) ? s_mem[int'(a)] : mem_default(a);
  endfunction

  // Frame-level reference: what a complete, non-overrun frame must produce
  task automatic model_frame(input logic [7:0] fb[$]);
    logic [15:0] a;
    exp_tx.push_back({6'b0, m_overrun, m_badop});
    m_overrun = 1'b0;
    m_badop   = 1'b0;
    if (fb[0] == 8'h01 || fb[0] == 8'h02) begin
      if (fb.size() >= 3) begin
        a = {fb[1], fb[2]};
        if (fb[0] == 8'h01) begin
          for (int i = 3; i < fb.size(); i++) begin
            exp_wr.push_back({a, fb[i]});
            m_mem[int'(a)] = fb[i];
            a = a + 16'd1;
          end
        end else begin
          for (int k = 0; k <= fb.size() - 3; k++) begin
            exp_rd.push_back(a);
            exp_tx.push_back(m_rd(a));
            a = a + 16'd1;
          end
        end
      end
    end else if (fb[0] != 8'h00) begin
      m_badop = 1'b1;
    end
  endtask

  task automatic pulse(input logic [7:0] b, input bit v, input bit fe);
    @(posedge clk); #1;
    rx_data   = b;
    rx_valid  = v;
    frame_end = fe;
    @(posedge clk); #1;
    rx_valid  = 1'b0;
    frame_end = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  // Wait for the sequencer to drain, then compare the sticky error flag
  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("idle_within_bound", 32'(n < 200), 32'd1);
    check("err_after_frame", 32'(err), 32'(m_overrun | m_badop));
  endtask

  task automatic send_frame(input logic [7:0] fb[$], input bit fe_last);
    model_frame(fb);
    for (int i = 0; i < fb.size(); i++) begin
      pulse(fb[i], 1'b1, fe_last && (i == fb.size() - 1));
      idle(GAP);
    end
    if (!fe_last) pulse(8'h00, 1'b0, 1'b1);
    wait_idle();
  endtask

  // Write slave: accepts after a random 0..3 cycle delay unless stalled
  initial begin
    wr_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rst || wr_stall) begin
        wr_ready = 1'b0;
        wr_wait  = 0;
      end else if (wr_valid) begin
        wr_ready = (wr_wait >= wr_lat);
        wr_wait++;
      end else begin
        wr_ready = 1'b0;
        wr_wait  = 0;
        wr_lat   = $urandom_range(0, 3);
      end
    end
  end

  // Read slave: acknowledges 0..2 cycles after the request
  initial begin
    rd_ack  = 1'b0;
    rd_data = 8'h00;
    forever begin
      @(posedge clk); #1;
      rd_ack = 1'b0;
      if (rst) begin
        rd_busy = 1'b0;
      end else begin
        if (rd_req) begin
          rd_busy = 1'b1;
          rd_a    = rd_addr;
          rd_cnt  = $urandom_range(0, 2);
        end
        if (rd_busy) begin
          if (rd_cnt == 0) begin
            rd_ack  = 1'b1;
            rd_data = s_rd(rd_a);
            rd_busy = 1'b0;
          end else begin
            rd_cnt--;
          end
        end
      end
    end
  end

  // Monitor: compare every handshake / tx_load against the scoreboard
  initial begin
    logic [23:0] e;
    logic [15:0] ea;
    logic [7:0]  et;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (wr_valid && wr_ready) begin
          s_mem[int'(wr_addr)] = wr_data;
          if (exp_wr.size() == 0) begin
            total++; bad++;
            $display("FAIL wr_unexpected: got addr 0x%0h data 0x%0h expected none", wr_addr, wr_data);
          end else begin
            e = exp_wr.pop_front();
            check("wr_addr", 32'(wr_addr), 32'(e[23:8]));
            check("wr_data", 32'(wr_data), 32'(e[7:0]));
          end
        end
        if (rd_req) begin
          if (exp_rd.size() == 0) begin
            total++; bad++;
            $display("FAIL rd_unexpected: got addr 0x%0h expected none", rd_addr);
          end else begin
            ea = exp_rd.pop_front();
            check("rd_addr", 32'(rd_addr), 32'(ea));
          end
        end
        if (tx_load) begin
          if (exp_tx.size() == 0) begin
            total++; bad++;
            $display("FAIL tx_unexpected: got 0x%0h expected none", tx_data);
          end else begin
            et = exp_tx.pop_front();
            check("tx_data", 32'(tx_data), 32'(et));
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0]  fr[$];
    logic [7:0]  op;
    logic [15:0] a;
    int          r;
    int          n_hdr;
    bit          fe_last;

    rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; frame_end = 1'b0;
    #1;
    check("rst_outputs", {tx_data, tx_load, wr_valid, rd_req, busy, err}, 32'd0);
    check("rst_addrs", {wr_addr, rd_addr}, 32'd0);
    idle(3); #1;
    rst = 1'b0;
    idle(2);

    // 1: plain write
    fr = {8'h01, 8'h12, 8'h34, 8'hAA, 8'hBB};
    send_frame(fr, 1'b0);

    // 2: read with prefetch, data for byte N shifts during byte N+1
    m_mem[16'h10] = 8'h5A; s_mem[16'h10] = 8'h5A;
    m_mem[16'h11] = 8'hC3; s_mem[16'h11] = 8'hC3;
    fr = {8'h02, 8'h00, 8'h10, 8'hFF, 8'hFF};
    send_frame(fr, 1'b0);

    // 3: backpressure -> overrun, byte dropped, status reported next frame
    fr = {8'h01, 8'h00, 8'h40, 8'h77};
    model_frame(fr);
    wr_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pulse(fr[i], 1'b1, 1'b0);
      if (i < 3) idle(GAP);
    end
    idle(9);
    pulse(8'h88, 1'b1, 1'b0);
    m_overrun = 1'b1;
    @(negedge clk);
    check("overrun_err", 32'(err), 32'd1);
    check("overrun_wr_held", 32'(wr_valid), 32'd1);
    idle(9); #1;
    wr_stall = 1'b0;
    idle(GAP);
    pulse(8'h00, 1'b0, 1'b1);
    wait_idle();
    fr = {8'h00};
    send_frame(fr, 1'b0);

    // 4: bad opcode, then status 0x01 on the next frame
    fr = {8'h7F};
    send_frame(fr, 1'b0);
    fr = {8'h00, 8'h55};
    send_frame(fr, 1'b0);

    // 5: address wrap
    fr = {8'h01, 8'hFF, 8'hFF, 8'h11, 8'h22};
    send_frame(fr, 1'b1);

    // 6: async reset while a write is held
    wr_stall = 1'b1;
    exp_tx.push_back({6'b0, m_overrun, m_badop});
    fr = {8'h01, 8'h00, 8'h20, 8'h55};
    for (int i = 0; i < 4; i++) begin
      pulse(fr[i], 1'b1, 1'b0);
      idle(GAP);
    end
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    check("midrst_outputs", {tx_data, tx_load, wr_valid, rd_req, busy, err}, 32'd0);
    check("midrst_addrs", {wr_addr, rd_addr}, 32'd0);
    m_overrun = 1'b0;
    m_badop   = 1'b0;
    idle(2); #1;
    rst = 1'b0;
    wr_stall = 1'b0;
    idle(2);
    fr = {8'h01, 8'h00, 8'h20, 8'h66};
    send_frame(fr, 1'b0);

    // Randomized frames
    for (int f = 0; f < 30; f++) begin
      fr = {};
      r  = $urandom_range(0, 9);
      if (r < 4)       op = 8'h01;
      else if (r < 8)  op = 8'h02;
      else if (r == 8) op = 8'h00;
      else             op = 8'($urandom_range(3, 255));
      fr.push_back(op);
      if (op == 8'h01 || op == 8'h02) begin
        a = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hFFFD, 16'hFFFF))
                                        : 16'($urandom_range(0, 16'hFFFF));
        n_hdr = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 1) : 2;
        if (n_hdr >= 1) fr.push_back(a[15:8]);
        if (n_hdr == 2) begin
          fr.push_back(a[7:0]);
          r = $urandom_range(0, 3);
          for (int j = 0; j < r; j++) fr.push_back(8'($urandom_range(0, 255)));
        end
      end else begin
        r = $urandom_range(0, 2);
        for (int j = 0; j < r; j++) fr.push_back(8'($urandom_range(0, 255)));
      end
      fe_last = 1'($urandom_range(0, 1));
      send_frame(fr, fe_last);
      idle($urandom_range(0, 5));
    end

    idle(10);
    check("wr_queue_drained", 32'(exp_wr.size()), 32'd0);
    check("rd_queue_drained", 32'(exp_rd.size()), 32'd0);
    check("tx_queue_drained", 32'(exp_tx.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
